// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
package bcd_pkg;

   localparam int DIGIT_W     = 4;
   localparam int HUND_W      = 2;
   localparam int BIN_W       = 8;
   localparam int NUM_SHIFTS  = 8;
   localparam int BCD_MAX_VAL = 255;
   localparam int WREG_W      = HUND_W + 2*DIGIT_W + BIN_W;
   localparam int CNT_W       = 4;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   // Flags digits that are not BCD, a hundreds digit of 3, or a value above BCD_MAX_VAL.
   function automatic logic range_err(input logic [HUND_W-1:0]  h,
                                      input logic [DIGIT_W-1:0] t,
                                      input logic [DIGIT_W-1:0] o);
      int val;
      val = int'(h)*100 + int'(t)*10 + int'(o);
      return (t > 4'd9) || (o > 4'd9) || (h == 2'd3) || (val > BCD_MAX_VAL);
   endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Reverse double-dabble correction for one BCD digit: subtract 3 when the digit is 8 or more.
module bcd_digit_adjust
   import bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] din,
   output logic [DIGIT_W-1:0] dout
);

   assign dout = (din >= 4'd8) ? din - 4'd3 : din;

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential 3-digit BCD to 8-bit binary converter, one shift-and-correct step per clock.
// Optional range checking is compiled in with `define BCD_RANGE_CHECK_EN.
module bcd_to_bin
   import bcd_pkg::*;
#(
   parameter logic [BIN_W-1:0] SAT_VALUE = 8'hFF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [HUND_W-1:0]   hundreds,
   input  logic [DIGIT_W-1:0]  tens,
   input  logic [DIGIT_W-1:0]  ones,
   output logic                busy,
   output logic                done,
   output logic [BIN_W-1:0]    bin,
   output logic                err
);

   state_t              state;
   logic [WREG_W-1:0]   wreg;
   logic [WREG_W-1:0]   shifted;
   logic [WREG_W-1:0]   stepped;
   logic [CNT_W-1:0]    cnt;
   logic [DIGIT_W-1:0]  t_adj;
   logic [DIGIT_W-1:0]  o_adj;

   // Layout {h, t, o, b}: bits shift out of the BCD fields into the binary field.
   assign shifted = wreg >> 1;

   bcd_digit_adjust u_adj_tens (
      .din  (shifted[BIN_W+2*DIGIT_W-1 -: DIGIT_W]),
      .dout (t_adj)
   );

   bcd_digit_adjust u_adj_ones (
      .din  (shifted[BIN_W+DIGIT_W-1 -: DIGIT_W]),
      .dout (o_adj)
   );

   assign stepped = {shifted[WREG_W-1 -: HUND_W], t_adj, o_adj, shifted[BIN_W-1:0]};

`ifndef BCD_RANGE_CHECK_EN
   logic [BIN_W-1:0] unused_sat;
   assign unused_sat = SAT_VALUE;
   assign err        = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         wreg  <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         bin   <= '0;
`ifdef BCD_RANGE_CHECK_EN
         err   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  wreg  <= {hundreds, tens, ones, {BIN_W{1'b0}}};
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= SHIFT;
`ifdef BCD_RANGE_CHECK_EN
                  err   <= range_err(hundreds, tens, ones);
`endif
               end else begin
                  state <= IDLE;
               end
            end
            SHIFT: begin
               wreg <= stepped;
               cnt  <= cnt + 1'b1;
               if (cnt == CNT_W'(NUM_SHIFTS-1)) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
`ifdef BCD_RANGE_CHECK_EN
                  bin   <= err ? SAT_VALUE : stepped[BIN_W-1:0];
`else
                  bin   <= stepped[BIN_W-1:0];
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Scoreboard bench for bcd_to_bin: expected results queued at accept, compared at done.
module tb_bcd_to_bin;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [1:0] hundreds;
   logic [3:0] tens;
   logic [3:0] ones;
   logic       busy;
   logic       done;
   logic [7:0] bin;
   logic       err;

   typedef struct {
      int bin;
      int err;
      int acc;
   } exp_t;

   exp_t sb[$];
   int   nchk = 0;
   int   nerr = 0;
   int   cyc  = 0;
   logic prev_done = 1'b0;

   bcd_to_bin #(.SAT_VALUE(8'hFF)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .hundreds (hundreds),
      .tens     (tens),
      .ones     (ones),
      .busy     (busy),
      .done     (done),
      .bin      (bin),
      .err      (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int obs, input int exp_v);
      nchk++;
      if (obs != exp_v) begin
         nerr++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp_v, exp_v);
      end
   endtask

   function automatic exp_t model(input int h, input int t, input int o);
      exp_t e;
      int   v;
      v     = h*100 + t*10 + o;
      e.bin = v % 256;
      e.err = 0;
`ifdef BCD_RANGE_CHECK_EN
      if (t > 9 || o > 9 || h == 3 || v > 255) begin
         e.err = 1;
         e.bin = 255;
      end
`endif
      e.acc = 0;
      return e;
   endfunction

   // Scoreboard side: every done pulse must match the oldest accepted request.
   always @(negedge clk) begin
      if (done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("bin", int'(bin), e.bin);
            chk("err", int'(err), e.err);
            chk("latency", cyc - e.acc, 8);
            chk("busy_at_done", int'(busy), 0);
         end
         chk("done_one_cycle", int'(prev_done), 0);
      end
      prev_done = done;
   end

   task automatic do_conv(input int h, input int t, input int o, input bit push);
      exp_t e;
      hundreds = 2'(h);
      tens     = 4'(t);
      ones     = 4'(o);
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (push) begin
         e     = model(h, t, o);
         e.acc = cyc;
         sb.push_back(e);
      end
   endtask

   task automatic wait_done();
      int got;
      got = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) begin
            got = 1;
            break;
         end
      end
      chk("done_timeout", got, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held with start asserted
      rst = 1'b1; start = 1'b1; hundreds = 2'd1; tens = 4'd2; ones = 4'd3;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_busy", int'(busy), 0);
         chk("rst_done", int'(done), 0);
         chk("rst_bin",  int'(bin),  0);
         chk("rst_err",  int'(err),  0);
      end
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("idle_busy", int'(busy), 0);
      end

      // Basic set
      do_conv(0, 0, 0, 1); wait_done();
      do_conv(0, 1, 5, 1); wait_done();
      do_conv(2, 4, 0, 1); wait_done();
      do_conv(2, 5, 5, 1); wait_done();

      // Random legal values
      for (int i = 0; i < 10; i++) begin
         int v;
         v = int'($urandom_range(0, 255));
         do_conv(v/100, (v/10)%10, v%10, 1);
         wait_done();
      end

      // Start during SHIFT is ignored; start in DONE is taken
      do_conv(1, 2, 3, 1);
      repeat (2) @(posedge clk);
      #1;
      hundreds = 2'd0; tens = 4'd0; ones = 4'd9; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; hundreds = 2'd2; tens = 4'd9; ones = 4'd9;
      wait_done();
      do_conv(0, 0, 9, 1);
      wait_done();

      // Range cases
      do_conv(2, 5, 6, 1); wait_done();
`ifdef BCD_RANGE_CHECK_EN
      do_conv(0, 10, 0, 1); wait_done();
      do_conv(3, 0, 0, 1);  wait_done();
`endif

      // Reset mid-conversion
      do_conv(1, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_busy", int'(busy), 0);
      chk("abort_bin",  int'(bin),  0);
      chk("abort_err",  int'(err),  0);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("abort_no_done", int'(done), 0);
      end
      do_conv(1, 0, 0, 1);
      wait_done();

      // Outputs hold while digits wander without start
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         hundreds = 2'($urandom_range(0, 3));
         tens     = 4'($urandom_range(0, 15));
         ones     = 4'($urandom_range(0, 15));
         if (i % 5 == 4) begin
            chk("hold_bin", int'(bin), 100);
            chk("hold_err", int'(err), 0);
         end
      end

      repeat (2) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/bcd_to_bin.md
Name: bcd_to_bin

Overview:
Sequential converter from 3-digit BCD (hundreds/tens/ones) to 8-bit binary. It is the inverse of the score display's binary-to-BCD path and serves keypad/switch entry of difficulty, target score and time limit. It uses a reverse double-dabble algorithm: one shift-and-correct step per clock, 8 steps per conversion. It has a start/busy/done handshake toward the game controller FSM.

Parameters:
SAT_VALUE, 8'hFF, binary output forced on an error when range checking is compiled in.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
start  input  1  request conversion; sampled only in IDLE or DONE
hundreds  input  2  BCD hundreds digit (0-2 legal)
tens  input  4  BCD tens digit
ones  input  4  BCD ones digit
busy  output  1  high while LOAD/SHIFT in progress
done  output  1  one-cycle pulse; bin valid
bin  output  8  binary result, held until next accepted start
err  output  1  input invalid/out of range; valid with done, held with bin

Behaviour:
- Reset (synchronous, active-high) applies on the clk edge where rst=1:
  - state=IDLE; busy=0, done=0, bin=0, err=0.
  - Working register and step counter are cleared.
- Working register: 18 bits, laid out as {h[1:0], t[3:0], o[3:0], b[7:0]}.
- States: IDLE, SHIFT, DONE.
- IDLE or DONE with start=1 at edge k:
  - Capture {hundreds,tens,ones,8'h00} into the working register.
  - cnt=0; state→SHIFT; busy=1 from k+1.
- SHIFT, each edge:
  - Shift the whole register right by 1.
  - Then, on the shifted tens and ones fields independently: if the field ≥ 8, subtract 3 (4-bit arithmetic).
  - The hundreds field is never corrected (max 3 < 8).
  - cnt increments.
- After the 8th shift (edge k+8):
  - state→DONE; busy=0; done=1 for one cycle; bin=reg[7:0].
- DONE without start → IDLE at the next edge; done drops.
- Latency: start edge k → done high in the cycle following edge k+8. Back-to-back throughput is 1 result per 9 cycles (start taken in DONE).
- start while in SHIFT is ignored; the input digits are don't-care after capture.
- Input digits are sampled only at the accept edge.
- For legal inputs (value ≤ 255) the BCD field is zero after 8 shifts.
- Without range checking: bin = value mod 256 for digit-valid input; the result for digits > 9 is deterministic but unspecified.
- rst during SHIFT aborts at that edge: all outputs return to reset values; no done pulse.
- rst and start on the same edge: reset wins.

Optional Feature:
Macro BCD_RANGE_CHECK_EN.
- Defined:
  - At the accept edge, err_next is set if any of these hold: tens>9, ones>9, hundreds=3, or the value exceeds 255 (h=2 and (t>5 or (t=5 and o>5))).
  - err is registered alongside the capture.
  - The conversion still runs the full 8 steps.
  - At done, bin=SAT_VALUE when err=1.
  - err holds until the next accept or reset.
- Undefined:
  - err is tied to 0.
  - No checking logic is present.
  - bin is the raw result.

Decomposition:
- Package bcd_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - NUM_SHIFTS=8;
  - BCD_MAX_VAL=255;
  - DIGIT_W=4, BIN_W=8.
- One natural sub-module, bcd_digit_adjust: a combinational 4-bit "if ≥ 8 then −3" unit, instantiated for the tens and ones fields.

Test Plan:
- Reset: assert rst 3 cycles with start=1 → busy=0, done=0, bin=0, err=0 throughout; no conversion starts.
- Basic set: convert {0,0,0}, {0,1,5}, {2,4,0}, {2,5,5} → bin=0x00, 0x0F, 0xF0, 0xFF, err=0. done asserts exactly 8 cycles after each start and lasts exactly 1 cycle.
- Handshake: pulse start for {1,2,3}; re-pulse start with {0,0,9} at cycle 3 → that pulse is ignored and bin=0x7B. Then start {0,0,9} in the DONE cycle → accepted, bin=0x09 nine cycles later.
- Range check with macro defined:
  - {2,5,6} → err=1, bin=0xFF.
  - {0,10,0} → err=1, bin=0xFF.
  - {3,0,0} → err=1, bin=0xFF.
  - Without the macro, {2,5,6} → err=0, bin=0x00 (256 mod 256).
- Reset mid-operation: start {1,0,0}, assert rst at cycle 4 → no done pulse, outputs at reset values. Then start {1,0,0} → bin=0x64.
- Held output: after done, change the digits without start for 20 cycles → bin and err unchanged.
